// File: rtl/fractal_sync_pkg.sv
// Shared types and constants for the fractal synchronization tree.
// Contents: source-field constant, initiator FSM states, initiator result codes,
// and a helper that sizes the initiator timeout counter.
package fractal_sync_pkg;

  // Source field carried on every request toward a tree node.
  localparam int unsigned SD_WIDTH = 2;
  localparam logic [SD_WIDTH-1:0] SD_SRC_CORE = SD_WIDTH'(1);

  // Initiator FSM states.
  typedef enum logic [1:0] {
    INIT_IDLE = 2'd0,
    INIT_SEND = 2'd1,
    INIT_WAIT = 2'd2,
    INIT_RESP = 2'd3
  } init_state_e;

  // Completion codes reported back to the core.
  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_NET      = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } sync_err_e;

  // Counter width for a given timeout.
  // A disabled timeout (0) still gets a legal 1-bit width.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/fractal_sync_timeout_cnt.sv
// Clear/enable saturating up-counter with a terminal-count flag.
// Ports: clk_i, rst_i (sync, active-high), clr_i (reset count to 0),
//        en_i (count up, saturating at all-ones), terminal_o (count == TERMINAL).
module fractal_sync_timeout_cnt #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned TERMINAL = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic terminal_o
);

  logic [WIDTH-1:0] cnt_q;

  // Clear has priority; saturate instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign terminal_o = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/fractal_sync_initiator.sv
// Core-side initiator of the fractal synchronization tree.
// Takes one barrier request from the core, sends it to the leaf node
// (valid/ready), waits for the wake-up, and reports a result code.
// Ports:
//   core_req_i/core_level_i/core_id_i  barrier request from the core
//   core_gnt_o                         request accepted (combinational, IDLE only)
//   core_rsp_valid_o/core_rsp_err_o    one-cycle completion pulse and code
//   req_valid_o/req_ready_i            request handshake toward the node
//   req_level_o/req_id_o/req_sd_o      request payload (latched fields, const source)
//   rsp_valid_i/rsp_level_i/rsp_id_i/rsp_err_i  wake-up from the node
//   stray_rsp_o                        wake-up seen outside WAIT (combinational)
module fractal_sync_initiator
  import fractal_sync_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH    = 1,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   core_req_i,
  input  logic [LEVEL_WIDTH-1:0] core_level_i,
  input  logic [ID_WIDTH-1:0]    core_id_i,
  output logic                   core_gnt_o,
  output logic                   core_rsp_valid_o,
  output logic [1:0]             core_rsp_err_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [LEVEL_WIDTH-1:0] req_level_o,
  output logic [ID_WIDTH-1:0]    req_id_o,
  output logic [SD_WIDTH-1:0]    req_sd_o,
  input  logic                   rsp_valid_i,
  input  logic [LEVEL_WIDTH-1:0] rsp_level_i,
  input  logic [ID_WIDTH-1:0]    rsp_id_i,
  input  logic                   rsp_err_i,
  output logic                   stray_rsp_o
);

  localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

  init_state_e            state_q, state_d;
  logic [LEVEL_WIDTH-1:0] level_q;
  logic [ID_WIDTH-1:0]    id_q;
  sync_err_e              code_q, code_d;
  logic                   done;
  logic                   timeout_hit;

  // Timeout counter: cleared on accept, counts WAIT cycles without a wake-up.
  if (TIMEOUT_CYCLES != 0) begin : g_timeout
    logic cnt_clr;
    logic cnt_en;
    assign cnt_clr = (state_q == INIT_IDLE) && core_req_i;
    assign cnt_en  = (state_q == INIT_WAIT) && !rsp_valid_i;
    fractal_sync_timeout_cnt #(
      .WIDTH    (CNT_W),
      .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (cnt_clr),
      .en_i       (cnt_en),
      .terminal_o (timeout_hit)
    );
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, grant, and result code; a wake-up beats a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    core_gnt_o = 1'b0;
    done       = 1'b0;
    code_d     = ERR_OK;
    if (rsp_err_i) begin
      code_d = ERR_NET;
    end else if ((rsp_level_i != level_q) || (rsp_id_i != id_q)) begin
      code_d = ERR_MISMATCH;
    end
    unique case (state_q)
      INIT_IDLE: begin
        core_gnt_o = core_req_i;
        if (core_req_i) begin
          state_d = INIT_SEND;
        end
      end
      INIT_SEND: begin
        if (req_ready_i) begin
          state_d = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        if (rsp_valid_i) begin
          done    = 1'b1;
          state_d = INIT_RESP;
        end else if (timeout_hit) begin
          code_d  = ERR_TIMEOUT;
          done    = 1'b1;
          state_d = INIT_RESP;
        end
      end
      INIT_RESP: begin
        state_d = INIT_IDLE;
      end
      default: begin
        state_d = INIT_IDLE;
      end
    endcase
  end

  // Request fields latch on grant; the code latches when WAIT resolves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      id_q    <= '0;
      code_q  <= ERR_OK;
    end else begin
      if (core_gnt_o) begin
        level_q <= core_level_i;
        id_q    <= core_id_i;
      end
      if (done) begin
        code_q <= code_d;
      end
    end
  end

  assign req_valid_o      = (state_q == INIT_SEND);
  assign core_rsp_valid_o = (state_q == INIT_RESP);
  assign core_rsp_err_o   = core_rsp_valid_o ? code_q : ERR_OK;
  assign req_level_o      = level_q;
  assign req_id_o         = id_q;
  assign req_sd_o         = SD_SRC_CORE;
  assign stray_rsp_o      = rsp_valid_i && (state_q != INIT_WAIT);

endmodule

// File: tb/tb_fractal_sync_initiator.sv
// Self-checking bench for fractal_sync_initiator: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against
// a transaction-level reference model.
module tb_fractal_sync_initiator;
  import fractal_sync_pkg::*;

  localparam int unsigned LW = 2;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          core_req_i = 1'b0;
  logic [LW-1:0] core_level_i = '0;
  logic [IW-1:0] core_id_i = '0;
  logic          core_gnt_o;
  logic          core_rsp_valid_o;
  logic [1:0]    core_rsp_err_o;
  logic          req_valid_o;
  logic          req_ready_i = 1'b0;
  logic [LW-1:0] req_level_o;
  logic [IW-1:0] req_id_o;
  logic [SD_WIDTH-1:0] req_sd_o;
  logic          rsp_valid_i = 1'b0;
  logic [LW-1:0] rsp_level_i = '0;
  logic [IW-1:0] rsp_id_i = '0;
  logic          rsp_err_i = 1'b0;
  logic          stray_rsp_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  fractal_sync_initiator #(
    .LEVEL_WIDTH    (LW),
    .ID_WIDTH       (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .core_req_i       (core_req_i),
    .core_level_i     (core_level_i),
    .core_id_i        (core_id_i),
    .core_gnt_o       (core_gnt_o),
    .core_rsp_valid_o (core_rsp_valid_o),
    .core_rsp_err_o   (core_rsp_err_o),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_level_o      (req_level_o),
    .req_id_o         (req_id_o),
    .req_sd_o         (req_sd_o),
    .rsp_valid_i      (rsp_valid_i),
    .rsp_level_i      (rsp_level_i),
    .rsp_id_i         (rsp_id_i),
    .rsp_err_i        (rsp_err_i),
    .stray_rsp_o      (stray_rsp_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // busy: a request is accepted and not yet resolved; in_wait: it has been
  // handed to the node; resp: the completion pulse is due this cycle.
  bit            m_ok = 0;
  bit            m_busy, m_in_wait, m_resp;
  logic [LW-1:0] m_lvl;
  logic [IW-1:0] m_id;
  logic [1:0]    m_code;
  int            m_entry;

  always @(negedge clk_i) begin
    if (m_ok) begin
      chk("m_gnt",       32'(core_gnt_o),       32'(!m_busy && !m_resp && core_req_i));
      chk("m_req_valid", 32'(req_valid_o),      32'(m_busy && !m_in_wait));
      chk("m_rsp_valid", 32'(core_rsp_valid_o), 32'(m_resp));
      if (m_resp) chk("m_rsp_err", 32'(core_rsp_err_o), 32'(m_code));
      chk("m_level",     32'(req_level_o),      32'(m_lvl));
      chk("m_id",        32'(req_id_o),         32'(m_id));
      chk("m_sd",        32'(req_sd_o),         1);
      chk("m_stray",     32'(stray_rsp_o),      32'(rsp_valid_i && !m_in_wait));
    end
    if (rst_i) begin
      m_ok = 1; m_busy = 0; m_in_wait = 0; m_resp = 0;
      m_lvl = '0; m_id = '0; m_code = 2'd0; m_entry = 0;
    end else if (m_ok) begin
      if (m_resp) begin
        m_resp = 0;
      end else if (!m_busy) begin
        if (core_req_i) begin
          m_busy = 1; m_lvl = core_level_i; m_id = core_id_i;
        end
      end else if (!m_in_wait) begin
        if (req_ready_i) begin
          m_in_wait = 1; m_entry = cyc + 1;
        end
      end else if (rsp_valid_i) begin
        m_code = rsp_err_i ? 2'd1 : ((rsp_level_i != m_lvl || rsp_id_i != m_id) ? 2'd2 : 2'd0);
        m_busy = 0; m_in_wait = 0; m_resp = 1;
      end else if (cyc - m_entry == int'(TO) - 1) begin
        m_code = 2'd3;
        m_busy = 0; m_in_wait = 0; m_resp = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One barrier from IDLE: ready after rdly stalled SEND cycles, wake-up
  // rspdly cycles into WAIT (negative: none). exp_lat counts from WAIT entry.
  task automatic do_txn(input logic [LW-1:0] lvl, input logic [IW-1:0] id,
                        input int rdly, input int rspdly,
                        input logic [LW-1:0] rl, input logic [IW-1:0] ri, input logic re,
                        input logic [1:0] exp_code, input int exp_lat);
    int w;
    bit got;
    core_req_i = 1'b1; core_level_i = lvl; core_id_i = id;
    req_ready_i = (rdly == 0);
    @(negedge clk_i);
    chk("txn_gnt", 32'(core_gnt_o), 1);
    step();
    if (rdly == 0) core_req_i = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk_i);
      chk("stall_valid", 32'(req_valid_o), 1);
      chk("stall_gnt",   32'(core_gnt_o), 0);
      chk("stall_level", 32'(req_level_o), 32'(lvl));
      chk("stall_id",    32'(req_id_o), 32'(id));
      step();
      if (i == rdly - 1) begin
        req_ready_i = 1'b1; core_req_i = 1'b0;
      end
    end
    @(negedge clk_i);
    chk("send_valid", 32'(req_valid_o), 1);
    chk("send_level", 32'(req_level_o), 32'(lvl));
    chk("send_id",    32'(req_id_o), 32'(id));
    step();
    req_ready_i = 1'b0;
    w = cyc;
    if (rspdly >= 0) begin
      repeat (rspdly) step();
      rsp_valid_i = 1'b1; rsp_level_i = rl; rsp_id_i = ri; rsp_err_i = re;
    end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (core_rsp_valid_o) begin
        got = 1;
        break;
      end
      step();
      rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
    end
    chk("txn_done", 32'(got), 1);
    if (got) begin
      chk("txn_code",    32'(core_rsp_err_o), 32'(exp_code));
      chk("txn_latency", 32'(cyc - w), 32'(exp_lat));
    end
    step();
  endtask

  initial begin
    repeat (2) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_gnt",   32'(core_gnt_o), 0);
    chk("rst_valid", 32'(req_valid_o), 0);
    chk("rst_rsp",   32'(core_rsp_valid_o), 0);
    chk("rst_err",   32'(core_rsp_err_o), 0);
    chk("rst_level", 32'(req_level_o), 0);
    chk("rst_id",    32'(req_id_o), 0);
    chk("rst_sd",    32'(req_sd_o), 1);
    chk("rst_stray", 32'(stray_rsp_o), 0);
    step();

    // Minimum latency, stalled handshake, error codes, timeout and its tie.
    do_txn(2'd1, 2'd0, 0,  0, 2'd1, 2'd0, 1'b0, 2'd0, 1);
    do_txn(2'd2, 2'd3, 5,  2, 2'd2, 2'd3, 1'b0, 2'd0, 3);
    do_txn(2'd1, 2'd0, 0,  1, 2'd1, 2'd0, 1'b1, 2'd1, 2);
    do_txn(2'd1, 2'd0, 0,  0, 2'd1, 2'd1, 1'b0, 2'd2, 1);
    do_txn(2'd3, 2'd1, 1, -1, 2'd0, 2'd0, 1'b0, 2'd3, 4);
    do_txn(2'd3, 2'd1, 0,  3, 2'd3, 2'd1, 1'b0, 2'd0, 4);

    // Stray wake-up in IDLE.
    rsp_valid_i = 1'b1; rsp_level_i = 2'd1;
    @(negedge clk_i);
    chk("stray_pulse", 32'(stray_rsp_o), 1);
    step();
    rsp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("stray_no_rsp",   32'(core_rsp_valid_o), 0);
    chk("stray_no_valid", 32'(req_valid_o), 0);
    step();

    // Reset while waiting, then a clean transaction.
    core_req_i = 1'b1; core_level_i = 2'd3; core_id_i = 2'd2; req_ready_i = 1'b1;
    step();
    core_req_i = 1'b0;
    repeat (2) step();
    req_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("wrst_valid", 32'(req_valid_o), 0);
    chk("wrst_rsp",   32'(core_rsp_valid_o), 0);
    chk("wrst_level", 32'(req_level_o), 0);
    chk("wrst_id",    32'(req_id_o), 0);
    chk("wrst_gnt",   32'(core_gnt_o), 0);
    step();
    do_txn(2'd1, 2'd0, 0, 0, 2'd1, 2'd0, 1'b0, 2'd0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_i        = ($urandom_range(0, 79) == 0);
      core_req_i   = $urandom_range(0, 1) == 1;
      core_level_i = LW'($urandom);
      core_id_i    = IW'($urandom);
      req_ready_i  = $urandom_range(0, 2) != 0;
      rsp_valid_i  = $urandom_range(0, 5) == 0;
      rsp_level_i  = ($urandom_range(0, 1) == 1) ? req_level_o : LW'($urandom);
      rsp_id_i     = ($urandom_range(0, 1) == 1) ? req_id_o : IW'($urandom);
      rsp_err_i    = $urandom_range(0, 7) == 0;
      step();
    end
    rst_i = 1'b0; core_req_i = 1'b0; rsp_valid_i = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fractal_sync_initiator.md
# fractal_sync_initiator

- Core-side initiator for the fractal synchronization tree; the requester end of the sync protocol that the tree node register files answer.
- Accepts one barrier request at a time from a processing element and drives it to the tree node port with a valid/ready handshake.
- Waits for the matching wake-up response and reports completion or an error code back to the core.
- One instance sits between each core and its leaf node.

## Interface
- LEVEL_WIDTH, default 1: width of the synchronization level field.
- ID_WIDTH, default 1: width of the barrier id field.
- TIMEOUT_CYCLES, default 0: cycles to wait in WAIT before declaring a timeout; 0 disables the timeout.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- core_req_i  in  1  core requests a barrier.
- core_level_i  in  LEVEL_WIDTH  level of the requested barrier.
- core_id_i  in  ID_WIDTH  barrier id.
- core_gnt_o  out  1  request accepted; high only in IDLE.
- core_rsp_valid_o  out  1  one-cycle completion pulse.
- core_rsp_err_o  out  2  result code, valid with core_rsp_valid_o.
- req_valid_o  out  1  sync request to the tree node.
- req_ready_i  in  1  node accepts the request.
- req_level_o  out  LEVEL_WIDTH  latched level.
- req_id_o  out  ID_WIDTH  latched id.
- req_sd_o  out  SD_WIDTH  source field; constant SD_SRC_CORE from the package.
- rsp_valid_i  in  1  wake-up from the node; no backpressure.
- rsp_level_i  in  LEVEL_WIDTH  level of the wake-up.
- rsp_id_i  in  ID_WIDTH  id of the wake-up.
- rsp_err_i  in  1  node-detected id or signature error.
- stray_rsp_o  out  1  pulse when rsp_valid_i arrives outside WAIT.

## Operation
- FSM states: IDLE, SEND, WAIT, RESP.
- IDLE:
  - core_gnt_o = core_req_i.
  - When core_req_i is high, latch level and id, clear the timeout counter, go to SEND.
- SEND:
  - req_valid_o = 1; level and id outputs held stable.
  - When req_ready_i is high, go to WAIT.
  - No timeout in SEND.
- WAIT:
  - When rsp_valid_i is high, go to RESP with one error code, in priority order:
    - rsp_err_i = 1 -> code 1 (ERR_NET).
    - else level or id does not match the latched values -> code 2 (ERR_MISMATCH).
    - else -> code 0 (OK).
  - When TIMEOUT_CYCLES != 0, the counter increments every WAIT cycle without a response.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response that cycle -> RESP with code 3 (ERR_TIMEOUT).
  - A response arriving in the same cycle as the timeout wins.
- RESP:
  - core_rsp_valid_o = 1 and core_rsp_err_o = the latched code, for exactly one cycle, then go to IDLE.
  - core_req_i is not granted in RESP.
- rsp_valid_i in IDLE, SEND or RESP: ignored for state; stray_rsp_o = 1 that cycle, combinational.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - State IDLE, counter 0, latched fields 0, code 0.
  - All outputs 0, except req_sd_o = SD_SRC_CORE, which is constant.
- Reset mid-operation: abandon the request and return to IDLE the next cycle; no response pulse.
- Grant at cycle T gives req_valid_o at T+1.
- Ready at cycle S gives WAIT at S+1.
- Response at cycle R gives core_rsp_valid_o at R+1.
- Minimum core-to-completion latency: gnt at T, rsp_valid_o at T+3.
- Back-to-back: a new grant is possible at R+2.
- Timeout: with TIMEOUT_CYCLES = N and WAIT entered at W, core_rsp_valid_o pulses at W+N.
- core_gnt_o, stray_rsp_o: combinational from state and inputs. All other outputs are registered or decoded from state.

## Structure
- Add to fractal_sync_pkg:
  - initiator state enum.
  - 2-bit error code type with ERR_OK, ERR_NET, ERR_MISMATCH, ERR_TIMEOUT.
  - SD_SRC_CORE constant of SD_WIDTH.
- One sub-module is natural: fractal_sync_timeout_cnt, a clear/enable saturating counter with a terminal flag; omitted via generate when TIMEOUT_CYCLES = 0.

## Test plan
- Reset, then core_req_i = 1 with level 1, id 0, and req_ready_i held high -> gnt at T, req_valid_o at T+1 carrying level 1 id 0; rsp 1/0 at T+2 -> rsp_valid_o at T+3 with code 0.
- req_ready_i low for 5 cycles -> req_valid_o stays high, fields stable, no grant; completes normally afterwards.
- rsp_err_i = 1 -> code 1. Response with id 1 against a latched id 0 -> code 2.
- TIMEOUT_CYCLES = 4 with no response -> code 3 exactly 4 cycles after WAIT entry. A response on the terminal cycle -> code 0.
- rsp_valid_i in IDLE -> stray_rsp_o = 1, state unchanged, no core_rsp_valid_o.
- rst_i asserted during WAIT -> next cycle all outputs at reset values. A following request completes with code 0.
